// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and forwarding-source encoding for the hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int REG_AW_DEF  = 5;
    localparam int NSRC_DEF    = 2;
    localparam int MEM_LAT_DEF = 1;

    // Where the winning producer's value comes from; SRC_WAIT means it is not available yet.
    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_WAIT,
        SRC_EX,
        SRC_MEM,
        SRC_SLOT
    } fwd_src_e;

    function automatic int track_depth(input int mem_lat);
        return mem_lat + 2;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Per-channel priority match across all tracked slots; the youngest (lowest index) producer wins.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int D       = MEM_LAT + 2
) (
    input  logic [REG_AW-1:0]         rs,
    input  logic [D-1:0]              slot_valid,
    input  logic [D-1:0]              slot_regwrite,
    input  logic [D-1:0]              slot_load,
    input  logic [D-1:0]              slot_ready,
    input  logic [D-1:0][REG_AW-1:0]  slot_rd,
    input  logic [D-1:0][XLEN-1:0]    slot_data,
    input  logic [XLEN-1:0]           ex_result,
    input  logic [XLEN-1:0]           mem_rdata,
    output logic                      hit,
    output logic                      ready,
    output logic [XLEN-1:0]           data
);

    fwd_src_e          src;
    logic [XLEN-1:0]   slot_val;

    // Walk oldest to youngest so the last match written is the youngest one.
    always_comb begin
        src      = SRC_NONE;
        slot_val = '0;
        for (int k = D - 1; k >= 0; k--) begin
            if (slot_valid[k] && slot_regwrite[k] && (rs != '0) && (slot_rd[k] == rs)) begin
                slot_val = slot_data[k];
                if (k == 0 && !slot_load[k])
                    src = SRC_EX;
                else if (k == MEM_LAT && slot_load[k])
                    src = SRC_MEM;
                else if (slot_ready[k])
                    src = SRC_SLOT;
                else
                    src = SRC_WAIT;
            end
        end
    end

    always_comb begin
        hit   = (src != SRC_NONE);
        ready = 1'b0;
        data  = '0;
        case (src)
            SRC_EX:   begin ready = 1'b1; data = ex_result; end
            SRC_MEM:  begin ready = 1'b1; data = mem_rdata; end
            SRC_SLOT: begin ready = 1'b1; data = slot_val;  end
            default:  begin ready = 1'b0; data = '0;        end
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes EX..WB, forwards the youngest ready value per source channel,
// and stalls ID on a not-yet-available load result.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NSRC    = NSRC_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [NSRC*REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]       id_rd,
    input  logic                    id_regwrite,
    input  logic                    id_load,
    input  logic                    flush,
    input  logic [XLEN-1:0]         ex_result,
    input  logic [XLEN-1:0]         mem_rdata,
    output logic [NSRC-1:0]         fwd_hit,
    output logic [NSRC*XLEN-1:0]    fwd_data,
    output logic                    stall,
    output logic [31:0]             stall_count
);

    localparam int D = track_depth(MEM_LAT);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              load;
        logic [XLEN-1:0]   data;
        logic              ready;
    } slot_t;

    slot_t [D-1:0] slot_q, slot_d;
    logic  [31:0]  stall_count_q, stall_count_d;

    logic [D-1:0]             s_valid, s_regwrite, s_load, s_ready;
    logic [D-1:0][REG_AW-1:0] s_rd;
    logic [D-1:0][XLEN-1:0]   s_data;
    logic [NSRC-1:0]          ch_ready;

    always_comb begin
        s_valid    = '0;
        s_regwrite = '0;
        s_load     = '0;
        s_ready    = '0;
        s_rd       = '0;
        s_data     = '0;
        for (int k = 0; k < D; k++) begin
            s_valid[k]    = slot_q[k].valid;
            s_regwrite[k] = slot_q[k].regwrite;
            s_load[k]     = slot_q[k].load;
            s_ready[k]    = slot_q[k].ready;
            s_rd[k]       = slot_q[k].rd;
            s_data[k]     = slot_q[k].data;
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_ch
        hazard_match #(
            .XLEN    (XLEN),
            .REG_AW  (REG_AW),
            .MEM_LAT (MEM_LAT),
            .D       (D)
        ) u_match (
            .rs            (id_rs[i*REG_AW +: REG_AW]),
            .slot_valid    (s_valid),
            .slot_regwrite (s_regwrite),
            .slot_load     (s_load),
            .slot_ready    (s_ready),
            .slot_rd       (s_rd),
            .slot_data     (s_data),
            .ex_result     (ex_result),
            .mem_rdata     (mem_rdata),
            .hit           (fwd_hit[i]),
            .ready         (ch_ready[i]),
            .data          (fwd_data[i*XLEN +: XLEN])
        );
    end

    assign stall       = id_valid && !flush && |(fwd_hit & ~ch_ready);
    assign stall_count = stall_count_q;

    always_comb begin
        slot_d[0] = '0;
        if (id_valid && !stall && !flush) begin
            slot_d[0].valid    = 1'b1;
            slot_d[0].rd       = id_rd;
            slot_d[0].regwrite = id_regwrite;
            slot_d[0].load     = id_load;
        end
        for (int k = 1; k < D; k++)
            slot_d[k] = slot_q[k-1];
        // ALU results are captured leaving EX; load data is captured leaving the last memory stage.
        if (!slot_q[0].load) begin
            slot_d[1].data  = ex_result;
            slot_d[1].ready = 1'b1;
        end
        if (slot_q[MEM_LAT].load) begin
            slot_d[MEM_LAT+1].data  = mem_rdata;
            slot_d[MEM_LAT+1].ready = 1'b1;
        end
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF))
            stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q        <= '0;
            stall_count_q <= '0;
        end else begin
            slot_q        <= slot_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with MEM_LAT=2 (four tracked slots) and two source channels.
module tb_hazard_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NSRC = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   id_valid;
    logic [NSRC*AW-1:0]     id_rs;
    logic [AW-1:0]          id_rd;
    logic                   id_regwrite;
    logic                   id_load;
    logic                   flush;
    logic [XLEN-1:0]        ex_result;
    logic [XLEN-1:0]        mem_rdata;
    logic [NSRC-1:0]        fwd_hit;
    logic [NSRC*XLEN-1:0]   fwd_data;
    logic                   stall;
    logic [31:0]            stall_count;

    int n_cmp = 0;
    int n_err = 0;

    hazard_scoreboard #(
        .XLEN(XLEN), .REG_AW(AW), .NSRC(NSRC), .MEM_LAT(2)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_load(id_load), .flush(flush),
        .ex_result(ex_result), .mem_rdata(mem_rdata), .fwd_hit(fwd_hit),
        .fwd_data(fwd_data), .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an ID instruction: valid, rs0, rs1, rd, regwrite, load, flush.
    task automatic drive(input logic v, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         input logic [AW-1:0] rd, input logic rw, input logic ld, input logic fl);
        id_valid    = v;
        id_rs       = {r1, r0};
        id_rd       = rd;
        id_regwrite = rw;
        id_load     = ld;
        flush       = fl;
    endtask

    // Let inputs settle, then checks run; next_cycle advances past the edge.
    task automatic settle();
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ex_result = '0;
        mem_rdata = '0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // No producers in flight
        drive(1, 3, 4, 0, 0, 0, 0); settle();
        chk("reset_hit", fwd_hit, 2'b00);
        chk("reset_stall", stall, 0);
        chk("reset_cnt", stall_count, 0);
        chk("reset_data", fwd_data, 64'h0);
        next_cycle();

        // ADD x5, then consume from EX, MEM1, MEM2, WB, then past WB
        drive(1, 0, 0, 5, 1, 0, 0); next_cycle();
        drive(1, 5, 0, 0, 0, 0, 0); ex_result = 32'h1234; settle();
        chk("alu_ex_hit", fwd_hit, 2'b01);
        chk("alu_ex_data", fwd_data[31:0], 32'h1234);
        chk("alu_ex_stall", stall, 0);
        next_cycle();
        drive(1, 0, 5, 0, 0, 0, 0); ex_result = 32'hDEAD; settle();
        chk("alu_s1_hit", fwd_hit, 2'b10);
        chk("alu_s1_data", fwd_data[63:32], 32'h1234);
        next_cycle();
        drive(1, 5, 5, 0, 0, 0, 0); settle();
        chk("alu_s2_hit", fwd_hit, 2'b11);
        chk("alu_s2_data", fwd_data, {32'h1234, 32'h1234});
        next_cycle();
        drive(1, 5, 0, 0, 0, 0, 0); settle();
        chk("alu_wb_hit", fwd_hit, 2'b01);
        chk("alu_wb_data", fwd_data[31:0], 32'h1234);
        next_cycle();
        settle();
        chk("retired_hit", fwd_hit, 2'b00);
        chk("retired_data", fwd_data[31:0], 32'h0);
        next_cycle();

        // Load x7 then use on rs2: two stall cycles, then mem_rdata forwarded
        drive(1, 0, 0, 7, 1, 1, 0); next_cycle();
        drive(1, 0, 7, 0, 0, 0, 0); settle();
        chk("lu_stall1", stall, 1);
        chk("lu_hit1", fwd_hit, 2'b10);
        next_cycle();
        settle();
        chk("lu_stall2", stall, 1);
        next_cycle();
        mem_rdata = 32'hCAFE; settle();
        chk("lu_stall3", stall, 0);
        chk("lu_hit3", fwd_hit, 2'b10);
        chk("lu_data3", fwd_data[63:32], 32'hCAFE);
        chk("lu_cnt", stall_count, 2);
        next_cycle();
        drive(1, 7, 0, 0, 0, 0, 0); mem_rdata = 32'h0; settle();
        chk("lu_wb_data", fwd_data[31:0], 32'hCAFE);
        chk("lu_wb_cnt", stall_count, 2);
        next_cycle();

        // ADD x9=0x11, then load x9, then use x9: the younger load wins
        drive(1, 0, 0, 9, 1, 0, 0); ex_result = 32'h11; next_cycle();
        drive(1, 0, 0, 9, 1, 1, 0); next_cycle();
        drive(1, 9, 0, 0, 0, 0, 0); settle();
        chk("yl_stall1", stall, 1);
        chk("yl_hit1", fwd_hit, 2'b01);
        next_cycle();
        settle();
        chk("yl_stall2", stall, 1);
        chk("yl_cnt2", stall_count, 3);
        next_cycle();
        mem_rdata = 32'h77; settle();
        chk("yl_stall3", stall, 0);
        chk("yl_data3", fwd_data[31:0], 32'h77);
        chk("yl_cnt3", stall_count, 4);
        next_cycle();

        // Load x10; flush during the use cycle, with an x11 writer in ID that gets killed
        drive(1, 0, 0, 10, 1, 1, 0); mem_rdata = 32'h0; next_cycle();
        drive(1, 10, 0, 11, 1, 0, 1); settle();
        chk("fl_stall", stall, 0);
        chk("fl_cnt", stall_count, 4);
        next_cycle();
        drive(1, 10, 11, 0, 0, 0, 0); settle();
        chk("fl_bubble_hit", fwd_hit, 2'b01);
        chk("fl_post_stall", stall, 1);
        chk("fl_post_cnt", stall_count, 4);
        next_cycle();

        // Writer to x0 must never be matched
        drive(1, 0, 0, 0, 1, 0, 0); settle();
        chk("x0_hit_a", fwd_hit, 2'b00);
        chk("x0_cnt", stall_count, 5);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0); settle();
        chk("x0_hit_b", fwd_hit, 2'b00);
        chk("x0_stall", stall, 0);
        next_cycle();

        // Three writers in flight, then reset discards them
        drive(1, 0, 0, 12, 1, 0, 0); ex_result = 32'h1; next_cycle();
        drive(1, 0, 0, 13, 1, 0, 0); next_cycle();
        drive(1, 0, 0, 14, 1, 0, 0); next_cycle();
        drive(1, 12, 13, 0, 0, 0, 0); settle();
        chk("pre_rst_hit", fwd_hit, 2'b11);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; settle();
        chk("rst_hit_a", fwd_hit, 2'b00);
        chk("rst_cnt", stall_count, 0);
        next_cycle();
        drive(1, 14, 0, 0, 0, 0, 0); settle();
        chk("rst_hit_b", fwd_hit, 2'b00);
        chk("rst_stall", stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
